// File: rtl/instr_issue_scheduler.sv
// Expands unrolled instruction-queue entries into one micro-op per cycle and
// routes each to the arithmetic, load/store or RAM unit. Optional ISSUE_SCHED_PERF_EN adds perf counters.
module instr_issue_scheduler #(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int ADDR_W                = 18
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             q_valid,
    output logic                             q_ready,
    input  logic [0:15]                      q_instr,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]   q_copies,
    input  logic [ADDR_W-1:0]                q_addr,
    input  logic [ADDR_W-1:0]                q_stride,
    output logic                             arith_valid,
    input  logic                             arith_ready,
    output logic                             ldst_valid,
    input  logic                             ldst_ready,
    output logic                             ram_valid,
    input  logic                             ram_ready,
    output logic [0:15]                      uop_instr,
    output logic [ADDR_W-1:0]                uop_addr,
    output logic                             idle,
    output logic                             err
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]                      perf_issued,
    output logic [31:0]                      perf_stall
`endif
);

    localparam int CNT_W = LOG_SUPERSCALAR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_COPIES = CNT_W'(1 << LOG_SUPERSCALAR_WIDTH);

    typedef enum logic [1:0] {
        INSTR_TYPE_ARITH = 2'd0,
        INSTR_TYPE_LD_ST = 2'd1,
        INSTR_TYPE_RAM   = 2'd2,
        INSTR_TYPE_LOOP  = 2'd3
    } e_instr_type;

    typedef enum logic {
        EMPTY = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [0:15]         cur_instr_q, cur_instr_d;
    logic [CNT_W-1:0]    cur_left_q, cur_left_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   cur_stride_q, cur_stride_d;
    logic                err_q, err_d;

    logic                active;
    logic                sel_ready;
    logic                fire;
    logic                last;
    logic                pop;
    logic                q_legal;
    e_instr_type         cur_type;
    e_instr_type         q_type;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        // A held entry is invisible while reset is high, so q_ready reads 1 and no unit fires.
        active    = (state_q == ISSUE) && !reset;
        cur_type  = e_instr_type'(cur_instr_q[0:1]);
        q_type    = e_instr_type'(q_instr[0:1]);

        arith_valid = active && (cur_type == INSTR_TYPE_ARITH);
        ldst_valid  = active && (cur_type == INSTR_TYPE_LD_ST);
        ram_valid   = active && (cur_type == INSTR_TYPE_RAM);

        sel_ready = 1'b0;
        case (cur_type)
            INSTR_TYPE_ARITH: sel_ready = arith_ready;
            INSTR_TYPE_LD_ST: sel_ready = ldst_ready;
            INSTR_TYPE_RAM:   sel_ready = ram_ready;
            default:          sel_ready = 1'b0;
        endcase

        fire    = active && sel_ready;
        last    = fire && (cur_left_q == CNT_W'(1));
        q_ready = !active || last;
        pop     = q_valid && q_ready && !reset;
        q_legal = (q_type != INSTR_TYPE_LOOP) && (q_copies != '0) && (q_copies <= MAX_COPIES);

        idle      = !active && !q_valid;
        uop_instr = cur_instr_q;
        uop_addr  = cur_addr_q;
        err       = err_q;

        state_d      = state_q;
        cur_instr_d  = cur_instr_q;
        cur_left_d   = cur_left_q;
        cur_addr_d   = cur_addr_q;
        cur_stride_d = cur_stride_q;
        err_d        = err_q;

        if (fire) begin
            if (last) begin
                state_d = EMPTY;
            end else begin
                cur_left_d = cur_left_q - CNT_W'(1);
                cur_addr_d = cur_addr_q + cur_stride_q;
            end
        end

        // A pop only happens with the slot empty or finishing, so an illegal entry leaves it empty.
        if (pop) begin
            if (q_legal) begin
                state_d      = ISSUE;
                cur_instr_d  = q_instr;
                cur_left_d   = q_copies;
                cur_addr_d   = q_addr;
                cur_stride_d = q_stride;
            end else begin
                state_d = EMPTY;
                err_d   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            cur_instr_q  <= '0;
            cur_left_q   <= '0;
            cur_addr_q   <= '0;
            cur_stride_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_instr_q  <= cur_instr_d;
            cur_left_q   <= cur_left_d;
            cur_addr_q   <= cur_addr_d;
            cur_stride_q <= cur_stride_d;
            err_q        <= err_d;
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (fire && (perf_issued_q != '1)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (active && !fire && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        perf_issued = perf_issued_q;
        perf_stall  = perf_stall_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end
`endif

endmodule
